// File: rtl/ram1_sram_model_pkg.sv
// Shared types and constants for the Ram1 SRAM responder model.
package ram1_pkg;

  localparam int RAM1_ADDR_PINS = 18;
  localparam int RAM1_DATA_W    = 16;
  localparam int RAM1_LAT_MAX   = 7;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WRITE_ACTIVE = 2'd1,
    ST_READ_WAIT    = 2'd2,
    ST_READ_DRIVE   = 2'd3
  } ram1_model_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [RAM1_DATA_W-1:0] sat_inc16(input logic [RAM1_DATA_W-1:0] v);
    logic [RAM1_DATA_W-1:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram1_sram_model_if.sv
// Ram1 controller pin bundle (address and strobes) plus responder status.
// The shared data bus is a separate inout port on the responder.
interface ram1_sram_model_if;
  import ram1_pkg::*;

  logic [RAM1_ADDR_PINS-1:0] ram_addr;
  logic                      ram_en;
  logic                      ram_oe;
  logic                      ram_we;
  logic                      busy;
  logic [RAM1_DATA_W-1:0]    wr_cnt;
  logic                      err;

  modport master (
    output ram_addr, ram_en, ram_oe, ram_we,
    input  busy, wr_cnt, err
  );

  modport slave (
    input  ram_addr, ram_en, ram_oe, ram_we,
    output busy, wr_cnt, err
  );

endinterface

// File: rtl/ram1_sram_model_mem.sv
// Single-port synchronous word array: one address shared by a write port and
// a registered read port. No reset so it maps onto block RAM.
module ram1_model_mem #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Write port and registered read port on the shared address.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram1_sram_model.sv
// Ram1 external-SRAM responder. Pins are sampled in the clk domain, writes
// commit one edge after WE release is sampled, reads drive the bus after
// READ_LAT edges (legal 1..RAM1_LAT_MAX).
// Optional build macro: RAM1_MODEL_ERRCHK_EN enables the sticky protocol
// error flag; otherwise err is tied low.
module ram1_sram_model
  import ram1_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  ram1_sram_model_if.slave       bus,
  inout  wire [RAM1_DATA_W-1:0]  ram_data
);

  logic                      s_en_q, s_oe_q, s_we_q;
  logic [RAM1_ADDR_PINS-1:0] s_addr_q;
  logic [RAM1_DATA_W-1:0]    s_data_q;

  ram1_model_state_t         state_q;
  logic                      busy_q;
  logic                      drive_q;
  logic [2:0]                cnt_q;
  logic [ADDR_W-1:0]         hold_addr_q;
  logic [RAM1_DATA_W-1:0]    hold_data_q;
  logic [RAM1_DATA_W-1:0]    wr_cnt_q;

  logic                      wr_req_s;
  logic                      rd_req_s;
  logic                      commit_s;
  logic                      rd_fetch_s;
  logic [ADDR_W-1:0]         mem_addr_s;
  logic [RAM1_DATA_W-1:0]    rdata_s;
  logic                      unused_s;

  // Register the raw Ram1 pins; everything downstream uses these samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_en_q   <= 1'b1;
      s_oe_q   <= 1'b1;
      s_we_q   <= 1'b1;
      s_addr_q <= '0;
      s_data_q <= '0;
    end else begin
      s_en_q   <= bus.ram_en;
      s_oe_q   <= bus.ram_oe;
      s_we_q   <= bus.ram_we;
      s_addr_q <= bus.ram_addr;
      s_data_q <= ram_data;
    end
  end

  // A read stays valid only while OE and EN are low and WE is high.
  assign wr_req_s = !s_en_q && !s_we_q;
  assign rd_req_s = !s_en_q && !s_oe_q && s_we_q;
  assign commit_s = (state_q == ST_WRITE_ACTIVE) && !s_en_q && s_we_q;
  // Fetch whenever the FSM will be in READ_DRIVE after this edge.
  assign rd_fetch_s = rd_req_s &&
                      (((state_q == ST_IDLE) && (READ_LAT == 1)) ||
                       ((state_q == ST_READ_WAIT) && (cnt_q == 3'd1)) ||
                       (state_q == ST_READ_DRIVE));
  // Reads and commits never coincide, so one address port suffices.
  assign mem_addr_s = commit_s ? hold_addr_q : s_addr_q[ADDR_W-1:0];
  // Upper address pins alias onto the implemented range.
  assign unused_s = ^s_addr_q[RAM1_ADDR_PINS-1:ADDR_W];

  ram1_model_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (RAM1_DATA_W)
  ) u_mem (
    .clk     (clk),
    .addr_i  (mem_addr_s),
    .we_i    (commit_s),
    .wdata_i (hold_data_q),
    .re_i    (rd_fetch_s),
    .rdata_o (rdata_s)
  );

  // Access FSM with registered busy, drive enable and write counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      drive_q     <= 1'b0;
      cnt_q       <= 3'd0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      wr_cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          drive_q <= 1'b0;
          if (wr_req_s) begin
            state_q     <= ST_WRITE_ACTIVE;
            busy_q      <= 1'b1;
            hold_addr_q <= s_addr_q[ADDR_W-1:0];
            hold_data_q <= s_data_q;
          end else if (rd_req_s) begin
            busy_q <= 1'b1;
            if (READ_LAT == 1) begin
              state_q <= ST_READ_DRIVE;
              drive_q <= 1'b1;
            end else begin
              state_q <= ST_READ_WAIT;
              cnt_q   <= 3'(READ_LAT - 1);
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_WRITE_ACTIVE: begin
          if (s_en_q) begin
            // Chip deselected before WE release: drop the write.
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (!s_we_q) begin
            hold_addr_q <= s_addr_q[ADDR_W-1:0];
            hold_data_q <= s_data_q;
          end else begin
            wr_cnt_q <= sat_inc16(wr_cnt_q);
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
          end
        end
        ST_READ_WAIT: begin
          if (!rd_req_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == 3'd1) begin
            state_q <= ST_READ_DRIVE;
            drive_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_READ_DRIVE: begin
          if (!rd_req_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            drive_q <= 1'b0;
          end else begin
            drive_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          drive_q <= 1'b0;
        end
      endcase
    end
  end

  assign ram_data   = drive_q ? rdata_s : {RAM1_DATA_W{1'bz}};
  assign bus.busy   = busy_q;
  assign bus.wr_cnt = wr_cnt_q;

`ifdef RAM1_MODEL_ERRCHK_EN
  logic err_q;
  logic s_we_prev_q;

  // Sticky flag: all three strobes low at once, or WE toggling mid-drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q       <= 1'b0;
      s_we_prev_q <= 1'b1;
    end else begin
      s_we_prev_q <= s_we_q;
      if ((!s_en_q && !s_oe_q && !s_we_q) ||
          ((state_q == ST_READ_DRIVE) && (s_we_q != s_we_prev_q))) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_ram1_sram_model.sv
// Randomized bench for ram1_sram_model. Two instances (READ_LAT 1 and 3)
// receive identical pin stimulus; a word-array reference model predicts
// read data, write count and bus release timing.
module tb_ram1_sram_model;

  logic        clk;
  logic        rst;
  logic        en_v, oe_v, we_v, tb_drv;
  logic [17:0] addr_v;
  logic [15:0] tb_data;
  wire  [15:0] bus1;
  wire  [15:0] bus3;

  int n_checks;
  int n_fail;

  logic [15:0] ref_mem [0:1023];
  logic [15:0] ref_cnt;
  logic [17:0] wq [$];

  ram1_sram_model_if ifa ();
  ram1_sram_model_if ifb ();

  assign ifa.ram_addr = addr_v;
  assign ifa.ram_en   = en_v;
  assign ifa.ram_oe   = oe_v;
  assign ifa.ram_we   = we_v;
  assign ifb.ram_addr = addr_v;
  assign ifb.ram_en   = en_v;
  assign ifb.ram_oe   = oe_v;
  assign ifb.ram_we   = we_v;

  assign bus1 = tb_drv ? tb_data : 16'hzzzz;
  assign bus3 = tb_drv ? tb_data : 16'hzzzz;

  // Pull-ups make an undriven bus read as all ones.
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup pu1 (bus1[i]);
    pullup pu3 (bus3[i]);
  end

  ram1_sram_model #(.ADDR_W(10), .READ_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(ifa), .ram_data(bus1)
  );

  ram1_sram_model #(.ADDR_W(10), .READ_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .bus(ifb), .ram_data(bus3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int idx(input logic [17:0] a);
    return int'(a) % 1024;
  endfunction

  // Random alias of an already written location.
  function automatic logic [17:0] pick();
    logic [17:0] a;
    a = wq[$urandom_range(0, wq.size() - 1)];
    return {8'($urandom_range(0, 255)), a[9:0]};
  endfunction

  task automatic bus_chk(input string tag, input logic [15:0] got, input int lat,
                         input int k, input int t, input logic [15:0] v);
    if (k >= lat && k <= t) begin
      chk(tag, 32'(got), 32'(v));
    end else begin
      chk({tag, "_z"}, 32'(got), 32'hFFFF);
    end
  endtask

  task automatic status_chk(input string tag, input logic busy_e);
    chk({tag, "_busy1"}, 32'(ifa.busy), 32'(busy_e));
    chk({tag, "_busy3"}, 32'(ifb.busy), 32'(busy_e));
    chk({tag, "_cnt1"}, 32'(ifa.wr_cnt), 32'(ref_cnt));
    chk({tag, "_cnt3"}, 32'(ifb.wr_cnt), 32'(ref_cnt));
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input int nlow,
                          input bit oe_low);
    en_v = 1'b0; we_v = 1'b0; oe_v = oe_low ? 1'b0 : 1'b1;
    addr_v = a; tb_data = d; tb_drv = 1'b1;
    for (int i = 0; i < nlow; i++) begin
      @(negedge clk);
      if (i >= 1) chk("wr_busy", 32'(ifa.busy), 32'd1);
    end
    we_v = 1'b1; oe_v = 1'b1;
    @(negedge clk);
    status_chk("wr_rel", 1'b1);
    en_v = 1'b1; tb_drv = 1'b0;
    @(negedge clk);
    ref_mem[idx(a)] = d;
    ref_cnt = (ref_cnt == 16'hFFFF) ? ref_cnt : ref_cnt + 16'd1;
    wq.push_back(a);
    status_chk("wr_done", 1'b0);
  endtask

  task automatic do_abort(input logic [17:0] a, input logic [15:0] d);
    en_v = 1'b0; we_v = 1'b0; oe_v = 1'b1;
    addr_v = a; tb_data = d; tb_drv = 1'b1;
    repeat (2) @(negedge clk);
    en_v = 1'b1;
    repeat (2) @(negedge clk);
    status_chk("abort", 1'b0);
    we_v = 1'b1; tb_drv = 1'b0;
    @(negedge clk);
  endtask

  // Request held for t sampled edges, then released; optional address changes.
  task automatic do_read(input logic [17:0] a0, input int t, input bit vary);
    logic [17:0] samp [0:15];
    logic [15:0] v;
    for (int k = 0; k <= t + 1; k++) begin
      if (k < t) begin
        en_v = 1'b0; oe_v = 1'b0; we_v = 1'b1;
        addr_v = (vary && k > 0) ? pick() : a0;
        samp[k] = addr_v;
      end else begin
        en_v = 1'b1; oe_v = 1'b1; we_v = 1'b1;
      end
      tb_drv = 1'b0;
      @(negedge clk);
      if (k >= 1) begin
        v = (k <= t) ? ref_mem[idx(samp[k-1])] : 16'h0000;
        bus_chk("rd_l1", bus1, 1, k, t, v);
        bus_chk("rd_l3", bus3, 3, k, t, v);
        chk("rd_busy1", 32'(ifa.busy), 32'(k <= t));
        chk("rd_busy3", 32'(ifb.busy), 32'(k <= t));
      end
    end
  endtask

  initial begin
    logic [17:0] a;
    logic        exp_err;
    n_checks = 0; n_fail = 0; ref_cnt = 16'd0;
    rst = 1'b1; en_v = 1'b1; oe_v = 1'b1; we_v = 1'b1;
    addr_v = 18'd0; tb_data = 16'd0; tb_drv = 1'b0;
    repeat (2) @(negedge clk);
    status_chk("reset", 1'b0);
    chk("reset_err1", 32'(ifa.err), 32'd0);
    chk("reset_err3", 32'(ifb.err), 32'd0);
    chk("reset_bus1", 32'(bus1), 32'hFFFF);
    chk("reset_bus3", 32'(bus3), 32'hFFFF);
    rst = 1'b0;
    @(negedge clk);

    // Write then read back, and aliasing across the upper address bits.
    do_write(18'h00012, 16'hA5C3, 3, 1'b0);
    do_read(18'h00012, 4, 1'b0);
    chk("wr_cnt_one", 32'(ifa.wr_cnt), 32'd1);
    do_write(18'h00400, 16'h1234, 2, 1'b0);
    do_read(18'h00000, 4, 1'b0);

    // Aborted write must leave the location untouched.
    do_abort(18'h00012, 16'h0BAD);
    do_read(18'h00012, 3, 1'b0);

    // Read with short holds and moving addresses.
    do_read(18'h00012, 1, 1'b0);
    do_read(18'h00000, 2, 1'b0);
    do_read(18'h00012, 6, 1'b1);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0, 1: do_write(18'($urandom), 16'($urandom_range(0, 65534)),
                       int'($urandom_range(1, 4)), 1'b0);
        2:    do_abort(pick(), 16'($urandom_range(0, 65534)));
        default: do_read(pick(), int'($urandom_range(1, 7)), 1'($urandom_range(0, 1)));
      endcase
    end

    // Reset while both instances drive the bus.
    a = pick();
    en_v = 1'b0; oe_v = 1'b0; we_v = 1'b1; addr_v = a;
    repeat (4) @(negedge clk);
    chk("pre_rst_bus1", 32'(bus1), 32'(ref_mem[idx(a)]));
    chk("pre_rst_bus3", 32'(bus3), 32'(ref_mem[idx(a)]));
    #2 rst = 1'b1;
    #1;
    ref_cnt = 16'd0;
    chk("rst_bus1", 32'(bus1), 32'hFFFF);
    chk("rst_bus3", 32'(bus3), 32'hFFFF);
    status_chk("rst_mid", 1'b0);
    en_v = 1'b1; oe_v = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_read(pick(), 4, 1'b0);

    // OE and WE low together: write wins; err only with the check built.
`ifdef RAM1_MODEL_ERRCHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    chk("err_before", 32'(ifa.err), 32'd0);
    do_write(18'h00155, 16'h5A5A, 2, 1'b1);
    chk("err_set1", 32'(ifa.err), 32'(exp_err));
    chk("err_set3", 32'(ifb.err), 32'(exp_err));
    do_read(18'h00155, 4, 1'b0);
    chk("err_sticky", 32'(ifa.err), 32'(exp_err));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
